// File: rtl/ptw_axi_arbiter.sv
// Page-table-walk read arbiter: shares one AXI read port between ITLB and DTLB,
// one outstanding read, round-robin on ties, watchdog abort of hung reads.
module ptw_axi_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_itlb_addr_valid,
    input  logic [ADDR_WIDTH-1:0] i_itlb_addr,
    output logic                  o_itlb_data_valid,
    output logic [DATA_WIDTH-1:0] o_itlb_data,
    output logic                  o_itlb_timeout,
    input  logic                  i_dtlb_addr_valid,
    input  logic [ADDR_WIDTH-1:0] i_dtlb_addr,
    output logic                  o_dtlb_data_valid,
    output logic [DATA_WIDTH-1:0] o_dtlb_data,
    output logic                  o_dtlb_timeout,
    output logic                  o_m_addr_valid,
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    input  logic                  i_m_addr_ready,
    input  logic                  i_m_data_valid,
    input  logic [DATA_WIDTH-1:0] i_m_data,
    output logic                  o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic                  r_pend_i, r_pend_d;
    logic [ADDR_WIDTH-1:0] r_addr_i, r_addr_d;
    logic                  r_owner;     // 0 = ITLB, 1 = DTLB
    logic                  r_last;      // requester served last, same encoding
    logic [CNT_WIDTH-1:0]  r_wd;

    logic                  w_req_i, w_req_d, w_pick_d, w_grant, w_wd_hit;
    logic [ADDR_WIDTH-1:0] w_addr_i, w_addr_d;

    // A pulse arriving in the granting cycle counts and carries the freshest address
    assign w_req_i  = r_pend_i | i_itlb_addr_valid;
    assign w_req_d  = r_pend_d | i_dtlb_addr_valid;
    assign w_addr_i = i_itlb_addr_valid ? i_itlb_addr : r_addr_i;
    assign w_addr_d = i_dtlb_addr_valid ? i_dtlb_addr : r_addr_d;
    assign w_pick_d = w_req_d & (~w_req_i | ~r_last);
    assign w_grant  = (r_state == S_IDLE) & (w_req_i | w_req_d);
    assign w_wd_hit = TO_EN && (r_wd == WD_LAST);
    assign o_busy   = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= S_IDLE;
            r_pend_i          <= 1'b0;
            r_pend_d          <= 1'b0;
            r_addr_i          <= '0;
            r_addr_d          <= '0;
            r_owner           <= 1'b0;
            r_last            <= 1'b1;
            r_wd              <= '0;
            o_itlb_data_valid <= 1'b0;
            o_itlb_data       <= '0;
            o_itlb_timeout    <= 1'b0;
            o_dtlb_data_valid <= 1'b0;
            o_dtlb_data       <= '0;
            o_dtlb_timeout    <= 1'b0;
            o_m_addr_valid    <= 1'b0;
            o_m_addr          <= '0;
        end else begin
            o_itlb_data_valid <= 1'b0;
            o_itlb_timeout    <= 1'b0;
            o_dtlb_data_valid <= 1'b0;
            o_dtlb_timeout    <= 1'b0;
            if (i_itlb_addr_valid) begin
                r_pend_i <= 1'b1;
                r_addr_i <= i_itlb_addr;
            end
            if (i_dtlb_addr_valid) begin
                r_pend_d <= 1'b1;
                r_addr_d <= i_dtlb_addr;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        o_m_addr_valid <= 1'b1;
                        o_m_addr       <= w_pick_d ? w_addr_d : w_addr_i;
                        r_owner        <= w_pick_d;
                        // Overrides the capture above: the granted pulse is consumed
                        if (w_pick_d) r_pend_d <= 1'b0;
                        else          r_pend_i <= 1'b0;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_m_addr_ready) begin
                        o_m_addr_valid <= 1'b0;
                        r_wd           <= '0;
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (i_m_data_valid) begin
                        if (r_owner) begin
                            o_dtlb_data_valid <= 1'b1;
                            o_dtlb_data       <= i_m_data;
                        end else begin
                            o_itlb_data_valid <= 1'b1;
                            o_itlb_data       <= i_m_data;
                        end
                        r_last  <= r_owner;
                        r_state <= S_IDLE;
                    end else if (w_wd_hit) begin
                        if (r_owner) o_dtlb_timeout <= 1'b1;
                        else         o_itlb_timeout <= 1'b1;
                        r_last  <= r_owner;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
